// File: rtl/stream_fifo_pkg.sv
// Shared defaults and pointer helpers for stream_fifo.
package stream_fifo_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_DATA_DEPTH = 16;

    // Pointers carry one extra wrap bit above the index; callers zero-extend them to 32 bits.
    function automatic logic ptr_full(input logic [31:0] wr, input logic [31:0] rd,
                                      input int unsigned aw);
        return (wr ^ rd) == (32'd1 << aw);
    endfunction

endpackage

// File: rtl/stream_fifo_mem.sv
// Storage array for stream_fifo: synchronous write, asynchronous read, no reset.
module stream_fifo_mem
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned DATA_DEPTH = DEF_DATA_DEPTH,
    parameter int unsigned ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [DATA_DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/stream_fifo.sv
// First-word-fall-through valid/ready FIFO with occupancy count and almost-full/empty flags.
// Define STREAM_FIFO_FLUSH_EN to add a synchronous active-high flush input.
module stream_fifo
    import stream_fifo_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned DATA_DEPTH    = DEF_DATA_DEPTH,
    parameter int unsigned ADDR_WIDTH    = $clog2(DATA_DEPTH),
    parameter int unsigned AFULL_THRESH  = DATA_DEPTH - 2,
    parameter int unsigned AEMPTY_THRESH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
`ifdef STREAM_FIFO_FLUSH_EN
    input  logic                  flush,
`endif
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  almost_full,
    output logic                  almost_empty
);

    if (DATA_DEPTH < 2 || (DATA_DEPTH & (DATA_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("stream_fifo: DATA_DEPTH must be a power of 2 and >= 2");
    end
    if (ADDR_WIDTH != unsigned'($clog2(DATA_DEPTH))) begin : g_bad_addr
        $error("stream_fifo: ADDR_WIDTH is derived and must not be overridden");
    end
    if (DATA_WIDTH < 1) begin : g_bad_width
        $error("stream_fifo: DATA_WIDTH must be >= 1");
    end

    localparam logic [ADDR_WIDTH:0] ONE        = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH:0] AFULL_LVL  = (ADDR_WIDTH + 1)'(AFULL_THRESH);
    localparam logic [ADDR_WIDTH:0] AEMPTY_LVL = (ADDR_WIDTH + 1)'(AEMPTY_THRESH);

    logic [ADDR_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0] count_q, count_d;
    logic                push, pop, do_write, flush_now;

`ifdef STREAM_FIFO_FLUSH_EN
    assign flush_now = flush;
`else
    assign flush_now = 1'b0;
`endif

    // Flags come only from registered pointers/count, so no input reaches an output.
    assign in_ready     = ~ptr_full(32'(wr_ptr_q), 32'(rd_ptr_q), ADDR_WIDTH);
    assign out_valid    = (wr_ptr_q != rd_ptr_q);
    assign count        = count_q;
    assign almost_full  = (count_q >= AFULL_LVL);
    assign almost_empty = (count_q <= AEMPTY_LVL);

    assign push     = in_valid & in_ready;
    assign pop      = out_valid & out_ready;
    assign do_write = push & ~flush_now;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_now) begin
            rd_ptr_d = wr_ptr_q;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + ONE;
            if (pop)  rd_ptr_d = rd_ptr_q + ONE;
            if (push && !pop)      count_d = count_q + ONE;
            else if (pop && !push) count_d = count_q - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    stream_fifo_mem #(
        .DATA_WIDTH (DATA_WIDTH),
        .DATA_DEPTH (DATA_DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_mem (
        .clk   (clk),
        .we    (do_write),
        .waddr (wr_ptr_q[ADDR_WIDTH-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr_q[ADDR_WIDTH-1:0]),
        .rdata (out_data)
    );

endmodule
